// File: rtl/lower_memory_responder.sv
// -----------------------------------------------------------------------------
// lower_memory_responder
//
// Backing-memory model that answers the L1 lower-memory request/ready
// handshake. A request is sampled in IDLE, the access is performed after a
// programmable number of clock edges, and a one-cycle mem_ready pulse reports
// completion. A stall input freezes the latency countdown so benches can
// inject back-pressure, and addresses beyond the backing store are flagged on
// mem_error instead of aliasing onto a valid word.
//
// Parameters
//   MEM_WORDS   number of 32-bit words in the backing store (power of two)
//   LATENCY     clock edges from request sample to mem_ready (>= 1)
//   ADDR_WIDTH  width of mem_address
//
// Ports
//   clk                in   clock
//   rst                in   synchronous active-high reset
//   mem_request        in   initiator request, held until mem_ready is seen
//   mem_write_enable   in   1 = write, 0 = read (sampled only in IDLE)
//   mem_address        in   byte address, bits [1:0] ignored
//   mem_write_data     in   full 32-bit write word
//   stall              in   freezes the latency countdown while in BUSY
//   mem_response_data  out  read data, valid with mem_ready on a read
//   mem_ready          out  one-cycle completion pulse
//   mem_error          out  pulses with mem_ready for an out-of-range address
//   busy               out  high whenever the responder is not IDLE
// -----------------------------------------------------------------------------
module lower_memory_responder #(
    parameter int MEM_WORDS  = 4096,
    parameter int LATENCY    = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_request,
    input  logic                  mem_write_enable,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [31:0]           mem_write_data,
    input  logic                  stall,
    output logic [31:0]           mem_response_data,
    output logic                  mem_ready,
    output logic                  mem_error,
    output logic                  busy
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    // A countdown from LATENCY-1 to 0 needs $clog2(LATENCY) bits; keep at
    // least one bit so LATENCY=1 still has a legal vector.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("lower_memory_responder: LATENCY must be at least 1");
        end
        if ((MEM_WORDS < 2) || ((MEM_WORDS & (MEM_WORDS - 1)) != 0)) begin : g_bad_words
            $error("lower_memory_responder: MEM_WORDS must be a power of two >= 2");
        end
        if (ADDR_WIDTH < IDX_W + 2) begin : g_bad_addr
            $error("lower_memory_responder: ADDR_WIDTH too narrow for MEM_WORDS");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;

    // Transaction fields captured at the sampling edge
    logic [IDX_W-1:0]  idx_reg;
    logic              we_reg;
    logic [31:0]       wdata_reg;
    logic              oor_reg;

    // Registered outputs
    logic              ready_reg;
    logic              ready_next;
    logic              error_reg;
    logic              error_next;
    logic              busy_reg;
    logic              busy_next;
    logic [31:0]       rdata_reg;

    logic              accept;
    logic              complete;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic              req_oor;
    logic [IDX_W-1:0]  req_idx;

    // Backing store; contents survive reset
    logic [31:0]       mem_array [MEM_WORDS];

    // Byte-offset bits carry no information for word accesses
    logic              addr_lsb_unused;
    assign addr_lsb_unused = &{1'b0, mem_address[1:0]};

    assign req_idx = mem_address[IDX_W+1:2];

    // Any set bit above the word index means the address is outside the
    // store. When the address is exactly as wide as the store, nothing can be
    // out of range.
    generate
        if (ADDR_WIDTH > IDX_W + 2) begin : g_range
            assign req_oor = |mem_address[ADDR_WIDTH-1:IDX_W+2];
        end else begin : g_norange
            assign req_oor = 1'b0;
        end
    endgenerate

    assign accept    = (state_reg == ST_IDLE) && mem_request;
    // The access happens on the BUSY edge that finds the countdown expired
    // and no stall applied.
    assign complete  = (state_reg == ST_BUSY) && !stall && (count_reg == '0);
    assign mem_wr_en = complete && we_reg && !oor_reg;
    assign mem_rd_en = complete && !we_reg;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem_request) begin
                    state_next = ST_BUSY;
                    count_next = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                if (!stall) begin
                    if (count_reg != '0) begin
                        count_next = count_reg - 1'b1;
                    end else begin
                        state_next = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: begin
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                // The initiator still holds the request of the completed
                // transaction; wait for it to drop so it is never re-accepted.
                if (!mem_request) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic (values registered below)
    // -------------------------------------------------------------------------
    always_comb begin
        ready_next = complete;
        error_next = complete && oor_reg;
        busy_next  = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_reg <= 1'b0;
            error_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            ready_reg <= ready_next;
            error_reg <= error_next;
            busy_reg  <= busy_next;
        end
    end

    // -------------------------------------------------------------------------
    // Request capture: later changes on the inputs do not affect the
    // transaction already in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg   <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            oor_reg   <= 1'b0;
        end else if (accept) begin
            idx_reg   <= req_idx;
            we_reg    <= mem_write_enable;
            wdata_reg <= mem_write_data;
            oor_reg   <= req_oor;
        end
    end

    // -------------------------------------------------------------------------
    // Backing store write port. Reset on the completion edge cancels the
    // write, so the enable is explicitly qualified here.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && mem_wr_en) begin
            mem_array[idx_reg] <= wdata_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Registered read port. Response data only changes on a read completion
    // (out-of-range reads return zero) and otherwise holds its last value.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (mem_rd_en) begin
            rdata_reg <= oor_reg ? 32'h0 : mem_array[idx_reg];
        end
    end

    assign mem_response_data = rdata_reg;
    assign mem_ready         = ready_reg;
    assign mem_error         = error_reg;
    assign busy              = busy_reg;

endmodule
